// File: rtl/trace_pkg.sv
// Shared definitions for the commit trace buffer: FSM state encoding and
// entry-field widths.
package trace_pkg;

  localparam int unsigned STATE_W    = 2;
  localparam int unsigned PC_W_DEF   = 32;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned RA_W_DEF   = 4;
  localparam int unsigned WB_W       = 1;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } trace_state_e;

endpackage

// File: rtl/trace_ram.sv
// Trace entry storage: one synchronous write port, one asynchronous read port.
module trace_ram #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 69
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/commit_trace_buffer.sv
// Commit trace buffer: captures retiring instructions around a PC/forced
// trigger, then drains the captured window oldest-first.
module commit_trace_buffer
  import trace_pkg::*;
#(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned POST_CNT = 3,
  parameter int unsigned PC_W     = PC_W_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned RA_W     = RA_W_DEF,
  parameter int unsigned WRAP     = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   arm,
  input  logic [PC_W-1:0]        trig_pc,
  input  logic                   trig_force,
  input  logic                   commit_valid,
  input  logic [PC_W-1:0]        commit_pc,
  input  logic [RA_W-1:0]        commit_rd,
  input  logic                   commit_wb,
  input  logic [DATA_W-1:0]      commit_data,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [PC_W-1:0]        rd_pc,
  output logic [RA_W-1:0]        rd_rd,
  output logic                   rd_wb,
  output logic [DATA_W-1:0]      rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic [STATE_W-1:0]     state,
  output logic                   dropped
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = PC_W + RA_W + WB_W + DATA_W;

  trace_state_e  state_q, state_d;
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d, post_q, post_d;
  logic          dropped_q, dropped_d;
  logic          we;
  logic          fire;
  logic [EW-1:0] rdata;

  trace_ram #(.DEPTH(DEPTH), .W(EW)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (wptr_q),
    .wdata ({commit_pc, commit_rd, commit_wb, commit_data}),
    .raddr (rptr_q),
    .rdata (rdata)
  );

  assign fire = trig_force || (commit_valid && (commit_pc == trig_pc));

  always_comb begin
    state_d   = state_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    count_d   = count_q;
    post_d    = post_q;
    dropped_d = dropped_q;
    we        = 1'b0;
    rd_valid  = (state_q == ST_DONE) && (count_q != '0);

    case (state_q)
      ST_IDLE: begin
        if (arm) begin
          state_d   = ST_ARMED;
          wptr_d    = '0;
          rptr_d    = '0;
          count_d   = '0;
          post_d    = '0;
          dropped_d = 1'b0;
        end
      end
      ST_ARMED, ST_POST: begin
        // Full buffer: wrap mode overwrites the oldest entry by moving both
        // pointers together, otherwise the commit is lost and flagged.
        if (commit_valid) begin
          if (count_q != CW'(DEPTH)) begin
            we      = 1'b1;
            wptr_d  = wptr_q + 1'b1;
            count_d = count_q + 1'b1;
          end else if (WRAP != 0) begin
            we     = 1'b1;
            wptr_d = wptr_q + 1'b1;
            rptr_d = rptr_q + 1'b1;
          end else begin
            dropped_d = 1'b1;
          end
        end
        if (state_q == ST_ARMED) begin
          if (fire) begin
            post_d  = '0;
            state_d = (POST_CNT == 0) ? ST_DONE : ST_POST;
          end
        end else if (commit_valid) begin
          post_d = post_q + 1'b1;
          if (post_q == CW'(POST_CNT - 1)) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (rd_valid && rd_ready) begin
          rptr_d  = rptr_q + 1'b1;
          count_d = count_q - 1'b1;
          if (count_q == CW'(1)) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      post_q    <= '0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      post_q    <= post_d;
      dropped_q <= dropped_d;
    end
  end

  assign rd_pc   = rdata[EW-1 -: PC_W];
  assign rd_rd   = rdata[DATA_W+WB_W +: RA_W];
  assign rd_wb   = rdata[DATA_W];
  assign rd_data = rdata[DATA_W-1:0];
  assign count   = count_q;
  assign state   = state_q;
  assign dropped = dropped_q;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Bench for commit_trace_buffer: three instances (wrap/POST_CNT=3,
// wrap/POST_CNT=0, no-wrap/POST_CNT=0), directed scenarios plus random traffic.
module tb_commit_trace_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        arm          [3];
  logic [31:0] trig_pc      [3];
  logic        trig_force   [3];
  logic        commit_valid [3];
  logic [31:0] commit_pc    [3];
  logic [3:0]  commit_rd    [3];
  logic        commit_wb    [3];
  logic [31:0] commit_data  [3];
  logic        rd_ready     [3];
  logic        rd_valid     [3];
  logic [31:0] rd_pc        [3];
  logic [3:0]  rd_rd        [3];
  logic        rd_wb        [3];
  logic [31:0] rd_data      [3];
  logic [3:0]  count        [3];
  logic [1:0]  state        [3];
  logic        dropped      [3];

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned P_WRAP = (g == 2) ? 0 : 1;
    localparam int unsigned P_POST = (g == 0) ? 3 : 0;
    commit_trace_buffer #(
      .DEPTH(8), .POST_CNT(P_POST), .PC_W(32), .DATA_W(32), .RA_W(4), .WRAP(P_WRAP)
    ) u_dut (
      .clk          (clk),
      .reset        (reset),
      .arm          (arm[g]),
      .trig_pc      (trig_pc[g]),
      .trig_force   (trig_force[g]),
      .commit_valid (commit_valid[g]),
      .commit_pc    (commit_pc[g]),
      .commit_rd    (commit_rd[g]),
      .commit_wb    (commit_wb[g]),
      .commit_data  (commit_data[g]),
      .rd_valid     (rd_valid[g]),
      .rd_ready     (rd_ready[g]),
      .rd_pc        (rd_pc[g]),
      .rd_rd        (rd_rd[g]),
      .rd_wb        (rd_wb[g]),
      .rd_data      (rd_data[g]),
      .count        (count[g]),
      .state        (state[g]),
      .dropped      (dropped[g])
    );
  end

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  rd;
    logic        wb;
    logic [31:0] data;
  } ent_t;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] dgen(input logic [31:0] pc);
    return (pc * 3) ^ 32'hC0DE_0000;
  endfunction

  task automatic idle_in(input int d);
    arm[d]          = 1'b0;
    trig_pc[d]      = 32'hFFFF_FFFF;
    trig_force[d]   = 1'b0;
    commit_valid[d] = 1'b0;
    commit_pc[d]    = '0;
    commit_rd[d]    = '0;
    commit_wb[d]    = 1'b0;
    commit_data[d]  = '0;
    rd_ready[d]     = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int d = 0; d < 3; d++) idle_in(d);
    cyc();
    cyc();
    reset = 1'b0;
    cyc();
  endtask

  task automatic arm_it(input int d);
    arm[d] = 1'b1;
    cyc();
    arm[d] = 1'b0;
  endtask

  task automatic commit_one(input int d, input logic [31:0] pc, input logic force_t);
    logic [31:0] p;
    p = pc;
    commit_valid[d] = 1'b1;
    commit_pc[d]    = p;
    commit_rd[d]    = p[5:2];
    commit_wb[d]    = p[2];
    commit_data[d]  = dgen(p);
    trig_force[d]   = force_t;
    cyc();
    commit_valid[d] = 1'b0;
    trig_force[d]   = 1'b0;
  endtask

  task automatic drain(input int d, input logic [31:0] first, input int n);
    logic [31:0] pc;
    rd_ready[d] = 1'b1;
    for (int i = 0; i < n; i++) begin
      pc = first + 32'(4 * i);
      chk("drain_rd_valid", 64'(rd_valid[d]), 64'(1));
      chk("drain_rd_pc", 64'(rd_pc[d]), 64'(pc));
      chk("drain_rd_data", 64'(rd_data[d]), 64'(dgen(pc)));
      chk("drain_rd_rd", 64'(rd_rd[d]), 64'(pc[5:2]));
      cyc();
    end
    rd_ready[d] = 1'b0;
    chk("drain_end_state", 64'(state[d]), 64'(0));
    chk("drain_end_count", 64'(count[d]), 64'(0));
    chk("drain_end_rd_valid", 64'(rd_valid[d]), 64'(0));
  endtask

  task automatic capture_basic(input int d);
    trig_pc[d] = 32'h10;
    arm_it(d);
    chk("basic_armed", 64'(state[d]), 64'(1));
    for (int i = 0; i < 8; i++) commit_one(d, 32'(4 * i), 1'b0);
    chk("basic_done_state", 64'(state[d]), 64'(3));
    chk("basic_done_count", 64'(count[d]), 64'(8));
    chk("basic_dropped", 64'(dropped[d]), 64'(0));
  endtask

  // Random traffic against a queue-based model of the capture/readout rules.
  task automatic rand_rounds(input int d, input int rounds, input int cycles);
    ent_t q[$];
    ent_t e;
    int   ms, mp, postc;
    bit   md, wrap;
    logic a, cv, tf, rr;
    logic [31:0] tpc;
    wrap  = (d != 2);
    postc = (d == 0) ? 3 : 0;
    for (int r = 0; r < rounds; r++) begin
      do_reset();
      q.delete();
      ms = 0; mp = 0; md = 1'b0;
      tpc = 32'($urandom_range(0, 15)) << 2;
      for (int c = 0; c < cycles; c++) begin
        a  = ($urandom_range(0, 7) == 0);
        cv = ($urandom_range(0, 1) == 1);
        tf = ($urandom_range(0, 15) == 0);
        rr = ($urandom_range(0, 1) == 1);
        e.pc   = 32'($urandom_range(0, 15)) << 2;
        e.rd   = 4'($urandom);
        e.wb   = 1'($urandom);
        e.data = $urandom;
        arm[d] = a; commit_valid[d] = cv; trig_force[d] = tf; rd_ready[d] = rr;
        trig_pc[d] = tpc; commit_pc[d] = e.pc; commit_rd[d] = e.rd;
        commit_wb[d] = e.wb; commit_data[d] = e.data;

        chk("rand_state", 64'(state[d]), 64'(ms));
        chk("rand_count", 64'(count[d]), 64'(q.size()));
        chk("rand_dropped", 64'(dropped[d]), 64'(md));
        chk("rand_rd_valid", 64'(rd_valid[d]), 64'((ms == 3) && (q.size() > 0)));
        if ((ms == 3) && (q.size() > 0)) begin
          chk("rand_rd_entry", 64'({rd_pc[d][15:0], rd_rd[d], rd_wb[d], rd_data[d]}),
              64'({q[0].pc[15:0], q[0].rd, q[0].wb, q[0].data}));
        end

        case (ms)
          0: if (a) begin q.delete(); md = 1'b0; mp = 0; ms = 1; end
          1, 2: begin
            if (cv) begin
              if (q.size() < 8) q.push_back(e);
              else if (wrap) begin void'(q.pop_front()); q.push_back(e); end
              else md = 1'b1;
            end
            if (ms == 1) begin
              if (tf || (cv && (e.pc == tpc))) begin mp = 0; ms = (postc == 0) ? 3 : 2; end
            end else if (cv) begin
              mp++;
              if (mp == postc) ms = 3;
            end
          end
          default: if ((q.size() > 0) && rr) begin
            void'(q.pop_front());
            if (q.size() == 0) ms = 0;
          end
        endcase
        cyc();
      end
      idle_in(d);
    end
  endtask

  initial begin
    do_reset();
    for (int d = 0; d < 3; d++) begin
      chk("reset_state", 64'(state[d]), 64'(0));
      chk("reset_count", 64'(count[d]), 64'(0));
      chk("reset_rd_valid", 64'(rd_valid[d]), 64'(0));
      chk("reset_dropped", 64'(dropped[d]), 64'(0));
    end

    // Basic capture and in-order readout.
    capture_basic(0);
    arm_it(0);
    chk("arm_ignored_in_done", 64'(state[0]), 64'(3));
    drain(0, 32'h0, 8);

    // Wrap: 12 commits, forced trigger on the last, POST_CNT=0.
    do_reset();
    arm_it(1);
    for (int i = 0; i < 12; i++) commit_one(1, 32'(4 * i), (i == 11));
    chk("wrap_state", 64'(state[1]), 64'(3));
    chk("wrap_count", 64'(count[1]), 64'(8));
    chk("wrap_dropped", 64'(dropped[1]), 64'(0));
    drain(1, 32'h10, 8);

    // Overflow without wrap.
    do_reset();
    arm_it(2);
    for (int i = 0; i < 10; i++) commit_one(2, 32'(4 * i), 1'b0);
    chk("ovf_still_armed", 64'(state[2]), 64'(1));
    trig_force[2] = 1'b1;
    cyc();
    trig_force[2] = 1'b0;
    chk("ovf_state", 64'(state[2]), 64'(3));
    chk("ovf_dropped", 64'(dropped[2]), 64'(1));
    chk("ovf_count", 64'(count[2]), 64'(8));
    drain(2, 32'h0, 8);
    chk("ovf_dropped_sticky", 64'(dropped[2]), 64'(1));
    arm_it(2);
    chk("ovf_rearm_clears_dropped", 64'(dropped[2]), 64'(0));

    // Backpressure in DONE.
    do_reset();
    capture_basic(0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_rd_pc", 64'(rd_pc[0]), 64'(32'h0));
      chk("bp_count", 64'(count[0]), 64'(8));
      cyc();
    end
    rd_ready[0] = 1'b1;
    cyc();
    rd_ready[0] = 1'b0;
    chk("bp_pop_rd_pc", 64'(rd_pc[0]), 64'(32'h4));
    chk("bp_pop_count", 64'(count[0]), 64'(7));
    drain(0, 32'h4, 7);

    // Reset in POST after two post-trigger commits.
    do_reset();
    trig_pc[0] = 32'h10;
    arm_it(0);
    for (int i = 0; i < 7; i++) commit_one(0, 32'(4 * i), 1'b0);
    chk("mid_post_state", 64'(state[0]), 64'(2));
    reset = 1'b1;
    cyc();
    chk("mid_reset_state", 64'(state[0]), 64'(0));
    chk("mid_reset_count", 64'(count[0]), 64'(0));
    chk("mid_reset_rd_valid", 64'(rd_valid[0]), 64'(0));
    reset = 1'b0;
    cyc();
    capture_basic(0);
    drain(0, 32'h0, 8);

    rand_rounds(0, 4, 80);
    rand_rounds(1, 3, 80);
    rand_rounds(2, 3, 80);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
